// File: rtl/seq_ram_buf.sv
// -----------------------------------------------------------------------------
// seq_ram_buf
//
// Sequential-access on-chip buffer between DMA-fed writers and PE-array readers.
// Words are written and read through auto-incrementing pointers over a single
// dual-port RAM of 2^ADDR_WIDTH words. A replay point (mark) can be saved on the
// read side; while it is held, the marked words are protected from overwrite
// and the read pointer can be rewound to it any number of times, so a tile is
// streamed in once and re-read without refetch.
//
// Parameters
//   DATA_WIDTH   word width in bits
//   ADDR_WIDTH   log2 of the buffer depth
//   RAM_TYPE     ram_style attribute applied to the storage array
//
// Ports
//   clk           single clock, rising edge
//   reset_n       asynchronous active-low reset
//   clear         synchronous flush (pointers, mark, flags, read register)
//   wr_req        write request
//   wr_data       write word
//   wr_ready      write will be accepted (= !full)
//   rd_req        read request
//   rd_data       registered read word, held until the next accepted read
//   rd_valid      one-cycle pulse: rd_data updated this cycle
//   mark          save current read pointer as replay point
//   rewind        restore read pointer to the replay point
//   mark_release  drop the replay point ("release" is a reserved word)
//   empty         no readable words
//   full          no writable slots (counted from the replay point if held)
//   count         readable words (wr_ptr - rd_ptr)
//   overflow      sticky: write attempted while full
//   underflow     sticky: read attempted while empty
// -----------------------------------------------------------------------------
module seq_ram_buf #(
    parameter int DATA_WIDTH = 10,
    parameter int ADDR_WIDTH = 12,
    parameter     RAM_TYPE   = "block"
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  wr_req,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    input  logic                  rd_req,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  mark,
    input  logic                  rewind,
    input  logic                  mark_release,
    output logic                  empty,
    output logic                  full,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Pointers carry one extra bit so that "full" and "empty" are
    // distinguishable; the low ADDR_WIDTH bits address the RAM.
    typedef logic [ADDR_WIDTH:0] ptr_t;
    localparam ptr_t DEPTH_PTR = ptr_t'(1) << ADDR_WIDTH;

    (* ram_style = RAM_TYPE *) logic [DATA_WIDTH-1:0] mem [DEPTH];

    ptr_t wr_ptr;
    ptr_t rd_ptr;
    ptr_t mark_ptr;
    logic mark_vld;

    ptr_t base;
    ptr_t held;
    logic wr_acc;
    logic rd_acc;
    logic do_rewind;
    logic do_mark;
    logic do_release;

    // Occupancy is measured from the replay point while one is held, so the
    // marked-but-already-read words still count against free space.
    assign base     = mark_vld ? mark_ptr : rd_ptr;
    assign held     = wr_ptr - base;
    assign full     = (held == DEPTH_PTR);
    assign empty    = (wr_ptr == rd_ptr);
    assign count    = wr_ptr - rd_ptr;
    assign wr_ready = ~full;

    // Acceptance uses registered state only: no same-cycle fall-through.
    assign wr_acc     = wr_req & ~full & ~clear;
    assign rd_acc     = rd_req & ~empty & ~rewind & ~clear;
    assign do_rewind  = rewind & mark_vld & ~clear;
    assign do_mark    = mark & ~rewind & ~clear;
    assign do_release = mark_release & ~mark & ~clear;

    // NOTE: the storage array has no reset so it maps onto RAM primitives;
    // every readable word has been written since the last reset/clear.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_data;
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples
    // the pre-edge values (mark_ptr captures rd_ptr before its increment).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            mark_ptr  <= '0;
            mark_vld  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            mark_ptr  <= '0;
            mark_vld  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rewind) begin
                rd_ptr <= mark_ptr;
            end else if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_mark) begin
                mark_ptr <= rd_ptr;
                mark_vld <= 1'b1;
            end else if (do_release) begin
                mark_vld <= 1'b0;
            end
            if (wr_req && full) begin
                overflow <= 1'b1;
            end
            // A read swallowed by a rewind is not an underflow.
            if (rd_req && empty && !rewind) begin
                underflow <= 1'b1;
            end
        end
    end

    // Read data register sits directly behind the RAM read port.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else if (clear) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_acc;
            if (rd_acc) begin
                rd_data <= mem[rd_ptr[ADDR_WIDTH-1:0]];
            end
        end
    end

endmodule

// File: tb/tb_seq_ram_buf.sv
// -----------------------------------------------------------------------------
// tb_seq_ram_buf
//
// Self-checking bench for seq_ram_buf with an 8-word buffer. A vector table
// covers the empty/rewind corners, hand-written sequences cover fill/drain,
// wrap, replay, rewind-vs-read and asynchronous reset, and a randomized phase
// runs against a reference model that tracks absolute word counts (unbounded
// integers) and a history of written words.
// -----------------------------------------------------------------------------
module tb_seq_ram_buf;

    localparam int DW    = 10;
    localparam int AW    = 3;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          clear;
    logic          wr_req;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic          rd_req;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          mark;
    logic          rewind;
    logic          rel;
    logic          empty;
    logic          full;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;

    seq_ram_buf #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .RAM_TYPE  ("block")
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear       (clear),
        .wr_req      (wr_req),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .rd_req      (rd_req),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .mark        (mark),
        .rewind      (rewind),
        .mark_release(rel),
        .empty       (empty),
        .full        (full),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------------------------------------------------------- model
    int            m_wr, m_rd, m_mk;
    bit            m_mkv, m_rv, m_of, m_uf;
    logic [DW-1:0] m_rdd;
    logic [DW-1:0] m_hist [int];

    task automatic model_reset();
        m_wr = 0; m_rd = 0; m_mk = 0;
        m_mkv = 0; m_rv = 0; m_of = 0; m_uf = 0;
        m_rdd = '0;
    endtask

    task automatic model_update(input bit wr, input logic [DW-1:0] wd, input bit rd,
                                input bit mk, input bit rw, input bit rl, input bit clr);
        int base;
        int old_rd;
        bit is_full;
        bit is_empty;
        if (clr) begin
            model_reset();
            return;
        end
        base     = m_mkv ? m_mk : m_rd;
        is_full  = (m_wr - base) == DEPTH;
        is_empty = (m_wr == m_rd);
        old_rd   = m_rd;
        m_rv     = 0;
        if (wr) begin
            if (is_full) m_of = 1;
            else begin
                m_hist[m_wr] = wd;
                m_wr++;
            end
        end
        if (rw) begin
            if (m_mkv) m_rd = m_mk;
        end else if (rd) begin
            if (is_empty) m_uf = 1;
            else begin
                m_rdd = m_hist[old_rd];
                m_rv  = 1;
                m_rd++;
            end
        end
        if (mk && !rw) begin
            m_mk  = old_rd;
            m_mkv = 1;
        end else if (rl && !mk) begin
            m_mkv = 0;
        end
    endtask

    task automatic check_model(input string tag);
        int base;
        base = m_mkv ? m_mk : m_rd;
        check({tag, ".rd_valid"},  32'(rd_valid),  32'(m_rv));
        check({tag, ".rd_data"},   32'(rd_data),   32'(m_rdd));
        check({tag, ".count"},     32'(count),     32'(m_wr - m_rd));
        check({tag, ".empty"},     32'(empty),     32'(m_wr == m_rd));
        check({tag, ".full"},      32'(full),      32'((m_wr - base) == DEPTH));
        check({tag, ".wr_ready"},  32'(wr_ready),  32'((m_wr - base) != DEPTH));
        check({tag, ".overflow"},  32'(overflow),  32'(m_of));
        check({tag, ".underflow"}, 32'(underflow), 32'(m_uf));
    endtask

    // One clock cycle: inputs are applied #1 after an edge, sampled at the
    // next edge, and outputs are compared #1 after that edge.
    task automatic drive(input string tag, input bit wr, input logic [DW-1:0] wd, input bit rd,
                         input bit mk, input bit rw, input bit rl, input bit clr);
        wr_req = wr; wr_data = wd; rd_req = rd;
        mark = mk; rewind = rw; rel = rl; clear = clr;
        model_update(wr, wd, rd, mk, rw, rl, clr);
        @(posedge clk);
        #1;
        check_model(tag);
        wr_req = 0; rd_req = 0; mark = 0; rewind = 0; rel = 0; clear = 0;
    endtask

    task automatic do_wr(input logic [DW-1:0] d);  drive("wr", 1, d, 0, 0, 0, 0, 0); endtask
    task automatic do_rd();                        drive("rd", 0, '0, 1, 0, 0, 0, 0); endtask
    task automatic do_clear();                     drive("clr", 0, '0, 0, 0, 0, 0, 1); endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".rd_data"},   32'(rd_data),   32'h0);
        check({tag, ".rd_valid"},  32'(rd_valid),  32'h0);
        check({tag, ".empty"},     32'(empty),     32'h1);
        check({tag, ".full"},      32'(full),      32'h0);
        check({tag, ".wr_ready"},  32'(wr_ready),  32'h1);
        check({tag, ".count"},     32'(count),     32'h0);
        check({tag, ".overflow"},  32'(overflow),  32'h0);
        check({tag, ".underflow"}, 32'(underflow), 32'h0);
    endtask

    // ---------------------------------------------------------------- table
    typedef struct {
        bit            wr;
        logic [DW-1:0] wd;
        bit            rd;
        bit            mk;
        bit            rw;
        bit            clr;
        bit            exp_rv;
        logic [DW-1:0] exp_rd;
        int            exp_cnt;
        bit            exp_empty;
        bit            exp_uf;
    } vec_t;

    vec_t tbl [11];

    initial begin
        reset_n = 0; clear = 0; wr_req = 0; wr_data = '0; rd_req = 0;
        mark = 0; rewind = 0; rel = 0;
        model_reset();

        // Empty-corner and rewind vectors:      wr  wd      rd mk rw clr | rv rd_data cnt emp uf
        tbl[0]  = '{0, 10'h000, 0, 0, 0, 1,  0, 10'h000, 0, 1, 0};
        tbl[1]  = '{1, 10'h011, 1, 0, 0, 0,  0, 10'h000, 1, 0, 1};  // rd+wr on empty
        tbl[2]  = '{0, 10'h000, 1, 0, 0, 0,  1, 10'h011, 0, 1, 1};
        tbl[3]  = '{0, 10'h000, 1, 0, 0, 0,  0, 10'h011, 0, 1, 1};  // rd_data holds
        tbl[4]  = '{1, 10'h022, 0, 0, 0, 0,  0, 10'h011, 1, 0, 1};
        tbl[5]  = '{1, 10'h033, 1, 0, 0, 0,  1, 10'h022, 1, 0, 1};
        tbl[6]  = '{1, 10'h044, 1, 1, 0, 0,  1, 10'h033, 1, 0, 1};  // mark at pre-read ptr
        tbl[7]  = '{0, 10'h000, 1, 0, 1, 0,  0, 10'h033, 2, 0, 1};  // rewind eats rd
        tbl[8]  = '{0, 10'h000, 1, 0, 0, 0,  1, 10'h033, 1, 0, 1};
        tbl[9]  = '{0, 10'h000, 1, 0, 0, 0,  1, 10'h044, 0, 1, 1};
        tbl[10] = '{1, 10'h3ff, 0, 0, 0, 1,  0, 10'h000, 0, 1, 0};  // clear beats wr

        // ---------------------------------------------------- reset state
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        reset_n = 1;

        // ---------------------------------------------------- vector table
        for (int i = 0; i < 11; i++) begin
            string t;
            t = $sformatf("vec%0d", i);
            drive(t, tbl[i].wr, tbl[i].wd, tbl[i].rd, tbl[i].mk, tbl[i].rw, 0, tbl[i].clr);
            check({t, ".rd_valid"},  32'(rd_valid),  32'(tbl[i].exp_rv));
            check({t, ".rd_data"},   32'(rd_data),   32'(tbl[i].exp_rd));
            check({t, ".count"},     32'(count),     32'(tbl[i].exp_cnt));
            check({t, ".empty"},     32'(empty),     32'(tbl[i].exp_empty));
            check({t, ".underflow"}, 32'(underflow), 32'(tbl[i].exp_uf));
        end

        // ---------------------------------------------------- fill / overflow / drain
        do_clear();
        for (int i = 0; i < DEPTH; i++) do_wr(DW'(i));
        check("fill.full", 32'(full), 32'h1);
        check("fill.count", 32'(count), 32'(DEPTH));
        do_wr(10'h3aa);
        check("fill.overflow", 32'(overflow), 32'h1);
        for (int i = 0; i < DEPTH; i++) begin
            do_rd();
            check($sformatf("drain%0d.rd_data", i), 32'(rd_data), 32'(i));
        end
        check("drain.empty", 32'(empty), 32'h1);

        // ---------------------------------------------------- wrap at half-full
        do_clear();
        for (int i = 0; i < DEPTH / 2; i++) do_wr(DW'(10'h200 + i));
        for (int i = DEPTH / 2; i < 3 * DEPTH + DEPTH / 2; i++) begin
            drive("wrap", 1, DW'(10'h200 + i), 1, 0, 0, 0, 0);
            check($sformatf("wrap%0d.rd_data", i), 32'(rd_data), 32'(10'h200 + i - DEPTH / 2));
            check($sformatf("wrap%0d.count", i), 32'(count), 32'(DEPTH / 2));
        end
        check("wrap.overflow", 32'(overflow), 32'h0);
        check("wrap.underflow", 32'(underflow), 32'h0);

        // ---------------------------------------------------- replay
        do_clear();
        for (int i = 0; i < 8; i++) do_wr(DW'(10'h0a0 + i));
        drive("mark", 0, '0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            do_rd();
            check($sformatf("replay1_%0d", i), 32'(rd_data), 32'(10'h0a0 + i));
        end
        check("replay.full_while_marked", 32'(full), 32'h1);
        check("replay.empty", 32'(empty), 32'h1);
        drive("rewind", 0, '0, 0, 0, 1, 0, 0);
        check("replay.count_after_rewind", 32'(count), 32'h8);
        for (int i = 0; i < 8; i++) begin
            do_rd();
            check($sformatf("replay2_%0d", i), 32'(rd_data), 32'(10'h0a0 + i));
        end
        drive("release", 0, '0, 0, 0, 0, 1, 0);
        check("replay.full_after_release", 32'(full), 32'h0);

        // ---------------------------------------------------- rewind + rd same cycle
        do_clear();
        for (int i = 0; i < 7; i++) do_wr(DW'(10'h150 + i));
        do_rd(); do_rd();
        drive("mark2", 0, '0, 0, 1, 0, 0, 0);
        do_rd(); do_rd(); do_rd();
        drive("rw_rd", 0, '0, 1, 0, 1, 0, 0);
        check("rw_rd.rd_valid", 32'(rd_valid), 32'h0);
        check("rw_rd.count", 32'(count), 32'h5);
        check("rw_rd.underflow", 32'(underflow), 32'h0);
        do_rd();
        check("rw_rd.next_data", 32'(rd_data), 32'h152);

        // ---------------------------------------------------- async reset mid-stream
        do_clear();
        for (int i = 0; i < 6; i++) do_wr(DW'(10'h2c0 + i));
        do_rd();
        check("pre_reset.count", 32'(count), 32'h5);
        #2;
        reset_n = 0;
        #1;
        check_reset_values("async_reset");
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1;
        do_wr(10'h155);
        do_rd();
        check("post_reset.rd_data", 32'(rd_data), 32'h155);
        check("post_reset.rd_valid", 32'(rd_valid), 32'h1);

        // ---------------------------------------------------- randomized vs model
        do_clear();
        for (int i = 0; i < 3000; i++) begin
            drive("rand",
                  $urandom_range(0, 99) < 60,
                  DW'($urandom_range(0, 1023)),
                  $urandom_range(0, 99) < 55,
                  $urandom_range(0, 99) < 5,
                  $urandom_range(0, 99) < 4,
                  $urandom_range(0, 99) < 4,
                  $urandom_range(0, 999) < 8);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
